mod_updown_counter: RTL
=======================

# mod_updown_counter

Parametrised up/down counter with programmable modulus, step size and wrap/saturate mode, plus event flags. It succeeds the fixed 4-bit load/up-down counter as the DUT of the counter verification environment. The counter sits behind a driver interface that carries the control inputs and a monitor interface that samples `count` and the flags.

## Interface
- `WIDTH`, 8: counter and data width.
- `STEP_W`, 4: width of the step input.
- `clock`  in  1: single clock; all state updates on posedge.
- `reset`  in  1: synchronous, active-high reset.
- `din`  in  WIDTH: load value.
- `load`  in  1: load `din` on this edge.
- `enable`  in  1: count on this edge.
- `up_down`  in  1: 1 = count up, 0 = count down.
- `step`  in  STEP_W: increment/decrement amount per enabled edge.
- `max_val`  in  WIDTH: terminal value; counting range is 0..`max_val`.
- `mode`  in  1: 0 = wrap (MODE_WRAP), 1 = saturate (MODE_SAT).
- `clr_flags`  in  1: clear `ovf_sticky`.
- `count`  out  WIDTH: current count, registered.
- `at_zero`  out  1: `count == 0`.
- `at_max`  out  1: `count == max_val`.
- `wrap`  out  1: one-cycle pulse; last count crossed the boundary in wrap mode.
- `sat_hit`  out  1: one-cycle pulse; last count was clipped in saturate mode.
- `ovf_sticky`  out  1: set by any `wrap` or `sat_hit` event; held until cleared.

## Operation
- Update priority per edge: `reset` > `load` > range clamp > `enable`. Otherwise `count` holds.
- **Reset:** `count`=0, `wrap`=0, `sat_hit`=0, `ovf_sticky`=0.
- **Load:** `count` <= min(`din`, `max_val`). No pulses are generated.
- **Range clamp:** if `count > max_val` (after `max_val` is lowered) and no load, `count` <= `max_val`. This overrides enable and generates no pulses.
- **Effective step:** s = min(`step`, `max_val`). With s = 0, count holds and no pulses are generated.
- **Up, no overflow:** if `count + s <= max_val`, `count` += s. Compute at WIDTH+1 bits.
- **Up, overflow, wrap mode:** `count` <= `count + s - (max_val + 1)`; pulse `wrap`.
- **Up, overflow, saturate mode:** `count` <= `max_val`; pulse `sat_hit`.
- **Down, no underflow:** if s <= `count`, `count` -= s.
- **Down, underflow, wrap mode:** `count` <= `count + max_val + 1 - s`; pulse `wrap`.
- **Down, underflow, saturate mode:** `count` <= 0; pulse `sat_hit`.
- **Saturate hold:** in saturate mode, an enabled step while already at the limit pulses `sat_hit` again.
- **`max_val` = 0:** count pinned at 0; no pulses.
- **`ovf_sticky`:** set when `wrap` or `sat_hit` is generated. `clr_flags` clears it; a set in the same cycle wins over clear. `reset` always clears it.

## Timing
- One-edge latency: controls sampled at edge N are visible on `count` and the pulses after edge N.
- `wrap` and `sat_hit` are registered. They are high for exactly the cycle in which `count` shows the post-event value.
- `ovf_sticky` rises in the same cycle as the pulse.
- `at_zero` and `at_max` are combinational from the `count` register and `max_val`. They change with `max_val` without waiting for a clock edge.
- A sustained `enable` produces one step per cycle; no bubbles.
- `reset` asserted mid-count: `count` = 0 after the next edge, independent of all other inputs.
- `load` and `enable` together: load wins; no step and no pulse that cycle.
- `mode` and `up_down` are sampled per edge and may change every cycle.

## Structure
- Package `counter_pkg`:
  - `typedef enum logic {MODE_WRAP, MODE_SAT} mode_e`.
  - Default `WIDTH` and `STEP_W` constants.
  - Transaction field widths shared with the driver and monitor classes.
- Sub-module `mod_step_calc` (combinational):
  - Inputs: `count`, s, `max_val`, `up_down`, `mode`.
  - Outputs: next count, `wrap_evt`, `sat_evt`.
- The top level holds the priority mux, the registers and the sticky flag.

## Test plan
Bench configuration: WIDTH=8, STEP_W=4.
- Reset, then `max_val`=9, step=1, up, wrap mode, enable for 12 cycles -> count 1..9, 0, 1, 2; `wrap` high only in the cycle count=0; `ovf_sticky`=1.
- `max_val`=200, step=7, count=196, up, saturate mode -> count=200 with `sat_hit` pulse; a further enabled cycle -> 200 with `sat_hit` again.
- Down, wrap mode, `max_val`=9, step=3, count=1 -> count=8 with `wrap` pulse; `at_zero`=0.
- `load`=1 with `din`=50, `max_val`=20, `enable`=1 -> count=20, no pulse; then lower `max_val` to 10 with enable=0 -> count=10 on the next edge.
- `clr_flags` in the same cycle as a `wrap` event -> `ovf_sticky` stays 1; `clr_flags` the following cycle -> `ovf_sticky`=0.
- `reset` during continuous counting at count=5 -> count=0, all flags 0 after one edge; counting resumes from 0 once `reset` drops.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types and widths for the up/down counter and its driver/monitor transactions.
package counter_pkg;

  // Boundary behaviour when a step would leave 0..max_val.
  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  localparam int unsigned DefaultWidth = 8;
  localparam int unsigned DefaultStepW = 4;

  // Transaction field widths used by the driver and monitor.
  localparam int unsigned TxnCountW = DefaultWidth;
  localparam int unsigned TxnStepW  = DefaultStepW;
  // Monitor flag vector: {ovf_sticky, sat_hit, wrap, at_max, at_zero}.
  localparam int unsigned TxnFlagsW = 5;

endpackage

// File: rtl/mod_step_calc.sv
// Combinational next-count calculation for one enabled step, including boundary events.
module mod_step_calc
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic [WIDTH-1:0] step_i,     // effective step, already limited to max_i
  input  logic [WIDTH-1:0] max_i,
  input  logic             up_down_i,
  input  mode_e            mode_i,
  output logic [WIDTH-1:0] next_o,
  output logic             wrap_evt_o,
  output logic             sat_evt_o
);

  logic [WIDTH:0]   sum_x;
  logic [WIDTH:0]   max_x;
  logic [WIDTH-1:0] up_wrap;
  logic [WIDTH-1:0] dn_wrap;

  // Overflow test needs the carry, so the sum is kept at WIDTH+1 bits.
  assign sum_x = {1'b0, count_i} + {1'b0, step_i};
  assign max_x = {1'b0, max_i};

  // True wrapped results always lie in 0..max_i, so modular WIDTH-bit arithmetic is exact.
  assign up_wrap = count_i + step_i - max_i - WIDTH'(1);
  assign dn_wrap = count_i + max_i + WIDTH'(1) - step_i;

  // Select the next count and flag a wrap or saturation event.
  always_comb begin
    next_o     = count_i;
    wrap_evt_o = 1'b0;
    sat_evt_o  = 1'b0;
    if (step_i != '0) begin
      if (up_down_i) begin
        if (sum_x <= max_x) begin
          next_o = sum_x[WIDTH-1:0];
        end else if (mode_i == MODE_WRAP) begin
          next_o     = up_wrap;
          wrap_evt_o = 1'b1;
        end else begin
          next_o    = max_i;
          sat_evt_o = 1'b1;
        end
      end else begin
        if (step_i <= count_i) begin
          next_o = count_i - step_i;
        end else if (mode_i == MODE_WRAP) begin
          next_o     = dn_wrap;
          wrap_evt_o = 1'b1;
        end else begin
          next_o    = '0;
          sat_evt_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Up/down counter with programmable modulus, step and wrap/saturate mode plus event flags.
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH  = DefaultWidth,
  parameter int unsigned STEP_W = DefaultStepW
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WIDTH-1:0]  din,
  input  logic              load,
  input  logic              enable,
  input  logic              up_down,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  max_val,
  input  logic              mode,
  input  logic              clr_flags,
  output logic [WIDTH-1:0]  count,
  output logic              at_zero,
  output logic              at_max,
  output logic              wrap,
  output logic              sat_hit,
  output logic              ovf_sticky
);

  logic [WIDTH-1:0]        count_q, count_d;
  logic                    wrap_q, wrap_d;
  logic                    sat_q, sat_d;
  logic                    ovf_q, ovf_d;
  logic [WIDTH+STEP_W-1:0] step_x, max_x;
  logic [WIDTH-1:0]        step_eff;
  logic [WIDTH-1:0]        calc_next;
  logic                    calc_wrap, calc_sat;

  // Compare step and max_val at a common width, then limit the step to max_val.
  assign step_x   = {{WIDTH{1'b0}}, step};
  assign max_x    = {{STEP_W{1'b0}}, max_val};
  assign step_eff = (step_x > max_x) ? max_val : step_x[WIDTH-1:0];

  mod_step_calc #(
    .WIDTH (WIDTH)
  ) u_step_calc (
    .count_i    (count_q),
    .step_i     (step_eff),
    .max_i      (max_val),
    .up_down_i  (up_down),
    .mode_i     (mode_e'(mode)),
    .next_o     (calc_next),
    .wrap_evt_o (calc_wrap),
    .sat_evt_o  (calc_sat)
  );

  // Priority: load, then range clamp, then enabled step; pulses only from a step.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    sat_d   = 1'b0;
    if (load) begin
      count_d = (din > max_val) ? max_val : din;
    end else if (count_q > max_val) begin
      count_d = max_val;
    end else if (enable) begin
      count_d = calc_next;
      wrap_d  = calc_wrap;
      sat_d   = calc_sat;
    end
    // A new event wins over a clear in the same cycle.
    ovf_d = ovf_q;
    if (wrap_d || sat_d) begin
      ovf_d = 1'b1;
    end else if (clr_flags) begin
      ovf_d = 1'b0;
    end
  end

  // Count and flag registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      sat_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      sat_q   <= sat_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count      = count_q;
  assign wrap       = wrap_q;
  assign sat_hit    = sat_q;
  assign ovf_sticky = ovf_q;
  assign at_zero    = (count_q == '0);
  assign at_max     = (count_q == max_val);

endmodule
